// File: rtl/memoria_dados_nrisc.sv
// nRisc data memory: 256x8 array behind a request/ready handshake with wait states.
// Optional MEMDADOS_PORTA_SAIDA_EN maps address all-ones to the PortaSaida register.
module memoria_dados_nrisc #(
  parameter int LARGURA_END = 8,
  parameter int LATENCIA    = 2
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic [LARGURA_END-1:0] EndMemDados,
  input  logic [7:0]             DadoEscritoMem,
  input  logic                   LerMem,
  input  logic                   EscMem,
  output logic [7:0]             DadoLidoMem,
  output logic                   Pronto,
  output logic                   Erro
`ifdef MEMDADOS_PORTA_SAIDA_EN
  ,
  output logic [7:0]             PortaSaida
`endif
);

  typedef enum logic [1:0] {
    OCIOSO,
    ESPERA,
    RESPONDE
  } estado_t;

  localparam logic [3:0] LAT = 4'(LATENCIA);

  estado_t                estado_q, estado_d;
  logic [3:0]             cont_q, cont_d;
  logic [LARGURA_END-1:0] end_q, end_d;
  logic [7:0]             dado_q, dado_d;
  logic                   ler_q, ler_d;
  logic                   esc_q, esc_d;
  logic [7:0]             lido_q, lido_d;
  logic [7:0]             porta_q, porta_d;

  logic [7:0] mem [2**LARGURA_END];

  logic                   captura;
  logic                   entra_resp;
  logic [LARGURA_END-1:0] acc_end;
  logic [7:0]             acc_dado;
  logic                   acc_ler;
  logic                   acc_esc;
  logic                   eh_porta;
  logic                   we;

  assign captura = (estado_q == OCIOSO) && (LerMem || EscMem);

  // With zero latency the capture edge is also the response edge,
  // so the access must use the live inputs rather than the latches.
  always_comb begin
    acc_end  = end_q;
    acc_dado = dado_q;
    acc_ler  = ler_q;
    acc_esc  = esc_q;
    if (estado_q == OCIOSO) begin
      acc_end  = EndMemDados;
      acc_dado = DadoEscritoMem;
      acc_ler  = LerMem;
      acc_esc  = EscMem;
    end
  end

`ifdef MEMDADOS_PORTA_SAIDA_EN
  assign eh_porta   = &acc_end;
  assign PortaSaida = porta_q;
`else
  assign eh_porta   = 1'b0;
`endif

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      estado_q <= OCIOSO;
      cont_q   <= '0;
      end_q    <= '0;
      dado_q   <= '0;
      ler_q    <= 1'b0;
      esc_q    <= 1'b0;
      lido_q   <= '0;
      porta_q  <= '0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
      end_q    <= end_d;
      dado_q   <= dado_d;
      ler_q    <= ler_d;
      esc_q    <= esc_d;
      lido_q   <= lido_d;
      porta_q  <= porta_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      OCIOSO:
        if (captura)
          estado_d = (LAT == 4'd0) ? RESPONDE : ESPERA;
      ESPERA:
        if (cont_q <= 4'd1)
          estado_d = RESPONDE;
      RESPONDE:
        estado_d = OCIOSO;
      default:
        estado_d = OCIOSO;
    endcase
  end

  assign entra_resp = (estado_d == RESPONDE) &&
                      (estado_q != RESPONDE);

  always_comb begin
    cont_d = cont_q;
    end_d  = end_q;
    dado_d = dado_q;
    ler_d  = ler_q;
    esc_d  = esc_q;
    if (captura) begin
      cont_d = LAT;
      end_d  = EndMemDados;
      dado_d = DadoEscritoMem;
      ler_d  = LerMem;
      esc_d  = EscMem;
    end else if (estado_q == ESPERA && cont_q != 4'd0) begin
      cont_d = cont_q - 4'd1;
    end else if (estado_q != ESPERA) begin
      cont_d = '0;
    end
  end

  always_comb begin
    lido_d  = '0;
    porta_d = porta_q;
    if (entra_resp && acc_ler && !acc_esc)
      lido_d = eh_porta ? porta_q : mem[acc_end];
    if (entra_resp && acc_esc && !acc_ler && eh_porta)
      porta_d = acc_dado;
  end

  // Gated by reset so an aborted or reset-time request never commits.
  assign we = Reset_n && entra_resp && acc_esc &&
              !acc_ler && !eh_porta;

  always_ff @(posedge Clock) begin
    if (we)
      mem[acc_end] <= acc_dado;
  end

  assign DadoLidoMem = lido_q;
  assign Pronto      = (estado_q == RESPONDE);
  assign Erro        = (estado_q == RESPONDE) && ler_q && esc_q;

endmodule

// File: tb/tb_memoria_dados_nrisc.sv
// Scoreboard bench for memoria_dados_nrisc: LATENCIA=2 and LATENCIA=0 instances.
// Define MEMDADOS_PORTA_SAIDA_EN to also exercise the output port.
module tb_memoria_dados_nrisc;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic       Reset_n;
  logic [7:0] end_a, din;
  logic       ler, esc;
  logic [7:0] lido;
  logic       pronto, erro;
  logic [7:0] end0, din0;
  logic       ler0, esc0;
  logic [7:0] lido0;
  logic       pronto0, erro0;
`ifdef MEMDADOS_PORTA_SAIDA_EN
  logic [7:0] porta, porta0;
`endif

  int vecs = 0;
  int errs = 0;
  logic [8:0] sb[$];
  logic [8:0] sb0[$];
  logic [8:0] e_sb, e_sb0;

  memoria_dados_nrisc #(.LARGURA_END(8), .LATENCIA(2)) u_dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .EndMemDados(end_a), .DadoEscritoMem(din),
    .LerMem(ler), .EscMem(esc),
    .DadoLidoMem(lido), .Pronto(pronto), .Erro(erro)
`ifdef MEMDADOS_PORTA_SAIDA_EN
    , .PortaSaida(porta)
`endif
  );

  memoria_dados_nrisc #(.LARGURA_END(8), .LATENCIA(0)) u_dut0 (
    .Clock(Clock), .Reset_n(Reset_n),
    .EndMemDados(end0), .DadoEscritoMem(din0),
    .LerMem(ler0), .EscMem(esc0),
    .DadoLidoMem(lido0), .Pronto(pronto0), .Erro(erro0)
`ifdef MEMDADOS_PORTA_SAIDA_EN
    , .PortaSaida(porta0)
`endif
  );

  task automatic chk(input string nome,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nome, got, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (pronto === 1'b1) begin
      if (sb.size() == 0) begin
        chk("pronto_sem_pedido", {15'b0, pronto}, 16'h0);
      end else begin
        e_sb = sb.pop_front();
        chk("resp", {7'b0, lido, erro}, {7'b0, e_sb});
      end
    end else begin
      chk("fora_resp", {7'b0, lido, erro}, 16'h0);
    end
  end

  always @(negedge Clock) begin
    if (pronto0 === 1'b1) begin
      if (sb0.size() == 0) begin
        chk("pronto0_sem_pedido", {15'b0, pronto0}, 16'h0);
      end else begin
        e_sb0 = sb0.pop_front();
        chk("resp0", {7'b0, lido0, erro0}, {7'b0, e_sb0});
      end
    end else begin
      chk("fora_resp0", {7'b0, lido0, erro0}, 16'h0);
    end
  end

  task automatic req(input logic [7:0] a, input logic [7:0] d,
                     input logic l, input logic e,
                     input logic [7:0] xd, input logic xe,
                     input logic muda);
    int n;
    sb.push_back({xd, xe});
    @(posedge Clock); #1;
    end_a = a; din = d; ler = l; esc = e;
    @(posedge Clock);
    if (muda) begin
      #1;
      end_a = ~a; din = ~d;
    end
    n = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (pronto) break;
      @(posedge Clock);
      n++;
    end
    chk("latencia", 16'(n), 16'd3);
    @(posedge Clock); #1;
    ler = 1'b0; esc = 1'b0;
  endtask

  initial begin
    int n;
    Reset_n = 1'b0;
    end_a = '0; din = '0; ler = 1'b0; esc = 1'b0;
    end0 = '0; din0 = '0; ler0 = 1'b0; esc0 = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    chk("reset_saidas", {6'b0, lido, pronto, erro}, 16'h0);
    Reset_n = 1'b1;
    repeat (10) @(negedge Clock);

    req(8'h10, 8'h5A, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    req(8'h10, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);

    req(8'h20, 8'h44, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    req(8'h20, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    req(8'h20, 8'h00, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0);

    req(8'hBF, 8'h66, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    req(8'h40, 8'h99, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    req(8'h40, 8'h00, 1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
    req(8'hBF, 8'h00, 1'b1, 1'b0, 8'h66, 1'b0, 1'b0);
    req(8'h40, 8'h00, 1'b1, 1'b0, 8'h99, 1'b0, 1'b1);

    req(8'h30, 8'h11, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    @(posedge Clock); #1;
    end_a = 8'h30; din = 8'h77; esc = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Reset_n = 1'b0;
    #1;
    chk("reset_espera", {6'b0, lido, pronto, erro}, 16'h0);
    esc = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    req(8'h30, 8'h00, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);

    sb.push_back({8'h5A, 1'b0});
    @(posedge Clock); #1;
    end_a = 8'h10; ler = 1'b1;
    @(posedge Clock);
    n = 0;
    while (n < 20 && !pronto) begin
      @(negedge Clock);
      n++;
    end
    chk("resp_vista", {15'b0, pronto}, 16'h1);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("reset_responde", {6'b0, lido, pronto, erro}, 16'h0);
    ler = 1'b0;
    @(posedge Clock); #1;
    Reset_n = 1'b1;

    req(8'hFF, 8'hC3, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
`ifdef MEMDADOS_PORTA_SAIDA_EN
    chk("porta_saida", {8'h0, porta}, 16'h00C3);
`endif
    req(8'hFF, 8'h00, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0);

    @(posedge Clock); #1;
    esc0 = 1'b1; end0 = 8'h10; din0 = 8'h5A;
    sb0.push_back({8'h00, 1'b0});
    @(posedge Clock);
    @(negedge Clock);
    chk("lat0_escrita", {15'b0, pronto0}, 16'h1);
    esc0 = 1'b0;
    @(posedge Clock); #1;
    ler0 = 1'b1;
    for (int i = 0; i < 4; i++) sb0.push_back({8'h5A, 1'b0});
    @(posedge Clock);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clock);
      chk("b2b_pronto", {15'b0, pronto0}, (i % 2 == 0) ? 16'h1 : 16'h0);
    end
    ler0 = 1'b0;

    repeat (4) @(negedge Clock);
    chk("fila_vazia", 16'(sb.size() + sb0.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
